// File: rtl/conv_rd_arb.sv
// Two-requester read arbiter sharing one read-address/read-response channel pair.
// Define CONV_RD_ARB_WT_PRIO_EN for fixed wt-over-ifm priority instead of round-robin.
module conv_rd_arb #(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] wt_req_addr,
  input  logic [31:0]       wt_req_len,
  input  logic              wt_req_valid,
  output logic              wt_req_ready,
  input  logic [AWIDTH-1:0] ifm_req_addr,
  input  logic [31:0]       ifm_req_len,
  input  logic              ifm_req_valid,
  output logic              ifm_req_ready,
  output logic [DWIDTH-1:0] wt_resp_data,
  output logic              wt_resp_valid,
  input  logic              wt_resp_ready,
  output logic [DWIDTH-1:0] ifm_resp_data,
  output logic              ifm_resp_valid,
  input  logic              ifm_resp_ready,
  output logic [AWIDTH-1:0] req_read_addr,
  output logic [31:0]       req_read_len,
  output logic              req_read_addr_valid,
  input  logic              req_read_addr_ready,
  input  logic [DWIDTH-1:0] resp_read_data,
  input  logic              resp_read_data_valid,
  output logic              resp_read_data_ready
);
  localparam int unsigned PW = $clog2(MAX_OUT);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [31:0]       r_len;
  logic              r_addr_valid;
  logic              r_tag_id  [MAX_OUT];
  logic [31:0]       r_tag_len [MAX_OUT];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic [31:0]       r_beat_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_grant_wt;
  logic        w_grant_ifm;
  logic        w_push;
  logic        w_pop;
  logic        w_beat;
  logic        w_resp_ok;
  logic        w_head_id;
  logic [31:0] w_head_len;
  logic [31:0] w_last_cnt;
  logic        w_prio_ifm;

`ifdef CONV_RD_ARB_WT_PRIO_EN
  assign w_prio_ifm = 1'b0;
`else
  logic r_prio_ifm;

  // Whoever wins a pick hands priority to the other requester.
  always_ff @(posedge clk) begin
    if (rst)              r_prio_ifm <= 1'b0;
    else if (w_grant_wt)  r_prio_ifm <= 1'b1;
    else if (w_grant_ifm) r_prio_ifm <= 1'b0;
  end

  assign w_prio_ifm = r_prio_ifm;
`endif

  assign w_full     = (r_count == (PW+1)'(MAX_OUT));
  assign w_empty    = (r_count == '0);
  assign w_head_id  = r_tag_id[r_rd_ptr];
  assign w_head_len = r_tag_len[r_rd_ptr];
  assign w_last_cnt = (w_head_len == '0) ? '0 : w_head_len - 32'd1;

  always_comb begin
    w_grant_wt  = 1'b0;
    w_grant_ifm = 1'b0;
    if (!rst && r_state == IDLE && !w_full) begin
      if (wt_req_valid && ifm_req_valid) begin
        w_grant_wt  = !w_prio_ifm;
        w_grant_ifm = w_prio_ifm;
      end else begin
        w_grant_wt  = wt_req_valid;
        w_grant_ifm = ifm_req_valid;
      end
    end
  end

  assign wt_req_ready  = w_grant_wt;
  assign ifm_req_ready = w_grant_ifm;
  assign w_push        = w_grant_wt || w_grant_ifm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_addr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_push) begin
          r_addr       <= w_grant_ifm ? ifm_req_addr : wt_req_addr;
          r_len        <= w_grant_ifm ? ifm_req_len : wt_req_len;
          r_addr_valid <= 1'b1;
          r_state      <= ISSUE;
        end
        ISSUE: if (req_read_addr_ready) begin
          r_addr_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_read_addr       = r_addr;
  assign req_read_len        = r_len;
  assign req_read_addr_valid = r_addr_valid && !rst;

  // Response path follows the oldest outstanding tag; gating with rst refuses stale beats.
  assign w_resp_ok            = !rst && !w_empty;
  assign resp_read_data_ready = w_resp_ok && (w_head_id ? ifm_resp_ready : wt_resp_ready);
  assign wt_resp_valid        = w_resp_ok && !w_head_id && resp_read_data_valid;
  assign ifm_resp_valid       = w_resp_ok && w_head_id && resp_read_data_valid;
  assign wt_resp_data         = resp_read_data;
  assign ifm_resp_data        = resp_read_data;
  assign w_beat               = resp_read_data_valid && resp_read_data_ready;
  assign w_pop                = w_beat && (r_beat_cnt == w_last_cnt);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_id[r_wr_ptr]  <= w_grant_ifm;
      r_tag_len[r_wr_ptr] <= w_grant_ifm ? ifm_req_len : wt_req_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_rd_arb.sv
// Scoreboard bench for conv_rd_arb: requests push expected address and beats, DUT outputs pop them.
module tb_conv_rd_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wt_req_addr, wt_req_len, ifm_req_addr, ifm_req_len;
  logic        wt_req_valid, wt_req_ready, ifm_req_valid, ifm_req_ready;
  logic [31:0] wt_resp_data, ifm_resp_data;
  logic        wt_resp_valid, wt_resp_ready, ifm_resp_valid, ifm_resp_ready;
  logic [31:0] req_read_addr, req_read_len;
  logic        req_read_addr_valid, req_read_addr_ready;
  logic [31:0] resp_read_data;
  logic        resp_read_data_valid, resp_read_data_ready;

  always #5 clk = ~clk;

  conv_rd_arb #(.AWIDTH(32), .DWIDTH(32), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .wt_req_addr(wt_req_addr), .wt_req_len(wt_req_len),
    .wt_req_valid(wt_req_valid), .wt_req_ready(wt_req_ready),
    .ifm_req_addr(ifm_req_addr), .ifm_req_len(ifm_req_len),
    .ifm_req_valid(ifm_req_valid), .ifm_req_ready(ifm_req_ready),
    .wt_resp_data(wt_resp_data), .wt_resp_valid(wt_resp_valid), .wt_resp_ready(wt_resp_ready),
    .ifm_resp_data(ifm_resp_data), .ifm_resp_valid(ifm_resp_valid), .ifm_resp_ready(ifm_resp_ready),
    .req_read_addr(req_read_addr), .req_read_len(req_read_len),
    .req_read_addr_valid(req_read_addr_valid), .req_read_addr_ready(req_read_addr_ready),
    .resp_read_data(resp_read_data), .resp_read_data_valid(resp_read_data_valid),
    .resp_read_data_ready(resp_read_data_ready)
  );

  typedef struct { logic [31:0] addr; logic [31:0] len; } areq_t;
  typedef struct { bit id; logic [31:0] data; } beat_t;
  typedef struct { logic [31:0] addr; logic [31:0] len; logic [31:0] idx; } rsp_t;

  areq_t q_areq[$];
  beat_t q_beat[$];
  rsp_t  q_rsp[$];

  int n_checks = 0;
  int n_errors = 0;
  int beats_seen = 0;
  bit got_wt, got_ifm, lat_pend, resp_en;
  bit stall_chk, full_chk, idle_chk, empty_chk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input bit id, input logic [31:0] a, input logic [31:0] l);
    logic [31:0] eff;
    eff = (l == 0) ? 32'd1 : l;
    q_areq.push_back('{a, l});
    for (int unsigned i = 0; i < eff; i++) q_beat.push_back('{id, a + i});
  endtask

  task automatic sample();
    areq_t e;
    beat_t b;
    rsp_t  r;
    got_wt  = wt_req_valid && wt_req_ready;
    got_ifm = ifm_req_valid && ifm_req_ready;
    if (lat_pend) chk("addr_valid_latency", req_read_addr_valid, 1);
    lat_pend = got_wt || got_ifm;
    if (got_wt)  push_req(1'b0, wt_req_addr, wt_req_len);
    if (got_ifm) push_req(1'b1, ifm_req_addr, ifm_req_len);
    if (full_chk) begin
      chk("full_wt_ready", wt_req_ready, 0);
      chk("full_ifm_ready", ifm_req_ready, 0);
    end
    if (stall_chk) begin
      chk("stall_data_ready", resp_read_data_ready, 0);
      chk("stall_ifm_valid", ifm_resp_valid, 0);
      chk("stall_wt_valid", wt_resp_valid, resp_read_data_valid);
    end
    if (empty_chk || idle_chk) begin
      chk("empty_data_ready", resp_read_data_ready, 0);
      chk("empty_wt_valid", wt_resp_valid, 0);
      chk("empty_ifm_valid", ifm_resp_valid, 0);
    end
    if (idle_chk) begin
      chk("idle_addr_valid", req_read_addr_valid, 0);
      chk("idle_wt_ready", wt_req_ready, 0);
      chk("idle_ifm_ready", ifm_req_ready, 0);
      if (!rst) begin
        chk("idle_addr", req_read_addr, 0);
        chk("idle_len", req_read_len, 0);
      end
    end
    if (req_read_addr_valid && req_read_addr_ready) begin
      chk("addr_expected", q_areq.size() != 0, 1);
      if (q_areq.size() != 0) begin
        e = q_areq.pop_front();
        chk("read_addr", req_read_addr, e.addr);
        chk("read_len", req_read_len, e.len);
        q_rsp.push_back('{e.addr, (e.len == 0) ? 32'd1 : e.len, 32'd0});
      end
    end
    if (resp_read_data_valid && resp_read_data_ready) begin
      beats_seen++;
      chk("beat_expected", q_beat.size() != 0, 1);
      if (q_beat.size() != 0) begin
        b = q_beat.pop_front();
        chk("wt_resp_valid", wt_resp_valid, !b.id);
        chk("ifm_resp_valid", ifm_resp_valid, b.id);
        chk("wt_resp_data", wt_resp_data, b.data);
        chk("ifm_resp_data", ifm_resp_data, b.data);
      end
      if (q_rsp.size() != 0) begin
        r = q_rsp.pop_front();
        r.idx++;
        if (r.idx != r.len) q_rsp.push_front(r);
      end
    end
  endtask

  task automatic drive_resp();
    if (resp_en && q_rsp.size() != 0) begin
      resp_read_data_valid = 1'b1;
      resp_read_data       = q_rsp[0].addr + q_rsp[0].idx;
    end else begin
      resp_read_data_valid = 1'b0;
      resp_read_data       = '0;
    end
  endtask

  task automatic cyc();
    drive_resp();
    #1;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit id, input logic [31:0] a, input logic [31:0] l, output int n);
    n = 0;
    if (id) begin ifm_req_addr = a; ifm_req_len = l; ifm_req_valid = 1'b1; end
    else    begin wt_req_addr = a;  wt_req_len = l;  wt_req_valid = 1'b1;  end
    do begin cyc(); n++; end while (!(id ? got_ifm : got_wt) && n < 50);
    chk(id ? "ifm_grant" : "wt_grant", id ? got_ifm : got_wt, 1);
    wt_req_valid  = 1'b0;
    ifm_req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q_beat.size() != 0 || q_rsp.size() != 0 || q_areq.size() != 0) && n < 300) begin
      cyc();
      n++;
    end
    chk(tag, q_beat.size() + q_rsp.size() + q_areq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wt_req_valid = 1'b0;
    ifm_req_valid = 1'b0;
    cyc();
    rst = 1'b0;
    q_areq.delete();
    q_beat.delete();
    q_rsp.delete();
    lat_pend = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gi, b0;
    bit exp_ord [4];
`ifdef CONV_RD_ARB_WT_PRIO_EN
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    rst = 1'b1;
    wt_req_addr = '0; wt_req_len = '0; wt_req_valid = 1'b0;
    ifm_req_addr = '0; ifm_req_len = '0; ifm_req_valid = 1'b0;
    wt_resp_ready = 1'b1; ifm_resp_ready = 1'b1; req_read_addr_ready = 1'b1;
    resp_read_data = '0; resp_read_data_valid = 1'b0;
    resp_en = 1'b0; lat_pend = 1'b0;
    stall_chk = 1'b0; full_chk = 1'b0; empty_chk = 1'b0;

    // Reset state
    idle_chk = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    idle_chk = 1'b0;

    // Single wt request, then a zero-length burst that must return one beat
    resp_en = 1'b1;
    req(1'b0, 32'h100, 32'd9, n);
    chk("single_grant_cycles", n, 1);
    drain("single_drain");
    empty_chk = 1'b1; cyc(); empty_chk = 1'b0;
    b0 = beats_seen;
    req(1'b0, 32'h180, 32'd0, n);
    drain("len0_drain");
    chk("len0_beats", beats_seen - b0, 1);
    empty_chk = 1'b1; cyc(); empty_chk = 1'b0;

    // Contention from a fresh reset
    do_reset();
    wt_req_addr = 32'h1000; wt_req_len = 32'd1;
    ifm_req_addr = 32'h2000; ifm_req_len = 32'd1;
    wt_req_valid = 1'b1; ifm_req_valid = 1'b1;
    gi = 0; n = 0;
    while (gi < 4 && n < 80) begin
      cyc();
      n++;
      if (got_wt || got_ifm) begin
        chk($sformatf("grant_order_%0d", gi), got_ifm, exp_ord[gi]);
        gi++;
        if (got_wt)  wt_req_addr  = wt_req_addr + 32'h10;
        if (got_ifm) ifm_req_addr = ifm_req_addr + 32'h10;
      end
    end
    chk("grant_count", gi, 4);
    wt_req_valid = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!(got_wt || got_ifm) && n < 40);
    chk("grant_after_wt_drop", got_ifm, 1);
    ifm_req_valid = 1'b0;
    drain("contention_drain");

    // Full tag FIFO: four len-2 bursts with no beats returned
    resp_en = 1'b0;
    for (int k = 0; k < 4; k++) req(1'b0, 32'h3000 + 32'h40 * k, 32'd2, n);
    cyc();
    cyc();
    chk("full_addr_issued", q_rsp.size(), 4);
    wt_req_addr = 32'h3400; wt_req_len = 32'd2; wt_req_valid = 1'b1;
    ifm_req_addr = 32'h3800; ifm_req_len = 32'd2; ifm_req_valid = 1'b1;
    full_chk = 1'b1;
    repeat (6) cyc();
    ifm_req_valid = 1'b0;
    resp_en = 1'b1;
    b0 = beats_seen; n = 0;
    while (beats_seen < b0 + 2 && n < 20) begin cyc(); n++; end
    full_chk = 1'b0;
    cyc();
    chk("full_accept_after_pop", got_wt, 1);
    wt_req_valid = 1'b0;
    drain("full_drain");

    // Backpressure on the head requester must stall the shared channel
    resp_en = 1'b0;
    req(1'b0, 32'h4000, 32'd3, n);
    req(1'b1, 32'h5000, 32'd2, n);
    cyc();
    cyc();
    wt_resp_ready = 1'b0;
    resp_en = 1'b1;
    stall_chk = 1'b1;
    repeat (5) cyc();
    stall_chk = 1'b0;
    wt_resp_ready = 1'b1;
    drain("backpressure_drain");

    // Reset while beat 2 of a len-5 burst is on the bus
    b0 = beats_seen;
    req(1'b0, 32'h6000, 32'd5, n);
    n = 0;
    while (beats_seen < b0 + 1 && n < 20) begin cyc(); n++; end
    chk("pre_reset_beats", beats_seen - b0, 1);
    rst = 1'b1;
    idle_chk = 1'b1;
    cyc();
    rst = 1'b0;
    q_areq.delete();
    q_beat.delete();
    lat_pend = 1'b0;
    repeat (3) cyc();
    idle_chk = 1'b0;
    q_rsp.delete();
    b0 = beats_seen;
    req(1'b1, 32'h7000, 32'd3, n);
    drain("post_reset_drain");
    chk("post_reset_beats", beats_seen - b0, 3);
    empty_chk = 1'b1; cyc(); empty_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
